// File: rtl/im_access_ctrl.sv
// Arbitrates the single-ported instruction memory between the CPU fetch port and the
// program loader: loader-only during boot, then fetch priority with a loader starvation guard.
module im_access_ctrl #(
    parameter int AW         = 14,
    parameter int DW         = 32,
    parameter int BOOT_BASE  = 3072,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          ld_last,
    output logic          ld_gnt,
    output logic          ld_err,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          cpu_stall,
    output logic          boot_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [AW-1:0] BASE_ADDR  = AW'(BOOT_BASE);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;
    logic          oor;
    logic          ld_in_range;

    assign ld_in_range = (ld_addr >= BASE_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            starve_cnt <= '0;
            if_rvalid  <= 1'b0;
            oor        <= 1'b0;
            ld_err     <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if_rvalid  <= if_gnt;
            oor        <= (if_addr < BASE_ADDR);
            ld_err     <= ld_gnt & ~ld_in_range;
        end
    end

    // At most one grant per cycle; the starvation counter only runs once booted.
    always_comb begin
        state_nxt  = state;
        starve_nxt = '0;
        ld_gnt     = 1'b0;
        if_gnt     = 1'b0;
        case (state)
            BOOT: begin
                ld_gnt = ld_req;
                if (ld_req && ld_last) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (ld_req && (starve_cnt == STARVE_LIM)) begin
                    ld_gnt = 1'b1;
                end else if (if_req) begin
                    if_gnt = 1'b1;
                end else begin
                    ld_gnt = ld_req;
                end
                if (ld_gnt) begin
                    starve_nxt = '0;
                end else if (ld_req) begin
                    starve_nxt = (starve_cnt == STARVE_LIM) ? STARVE_LIM : starve_cnt + 1'b1;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    // RUN is only ever entered by accepting the last boot word, so it doubles as the sticky flag.
    assign boot_done = (state == RUN);
    assign cpu_stall = ~boot_done | (if_req & ~if_gnt);
    assign mem_en    = ld_gnt | if_gnt;
    assign mem_we    = ld_gnt & ld_in_range;
    assign mem_addr  = ld_gnt ? ld_addr : if_addr;
    assign mem_wdata = ld_wdata;
    assign if_rdata  = oor ? '0 : mem_rdata;

endmodule

// File: tb/tb_im_access_ctrl.sv
// Self-checking bench for im_access_ctrl: directed boot/starvation/out-of-range/reset scenarios
// followed by randomized traffic, checked against a cycle-level reference model and a fetch scoreboard.
module tb_im_access_ctrl;

    localparam int AW   = 14;
    localparam int DW   = 32;
    localparam int BASE = 3072;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;
    logic          ld_last = 1'b0;
    logic          ld_gnt;
    logic          ld_err;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          cpu_stall;
    logic          boot_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    im_access_ctrl #(.AW(AW), .DW(DW), .BOOT_BASE(BASE), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_last(ld_last),
        .ld_gnt(ld_gnt), .ld_err(ld_err),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .cpu_stall(cpu_stall), .boot_done(boot_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Instruction memory: 1-cycle synchronous read; low addresses hold junk so the nop forcing is visible.
    bit [31:0] tbmem [0:16383];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tbmem[mem_addr] = mem_wdata;
            else if (int'(mem_addr) < BASE) mem_rdata <= {18'h0, mem_addr} ^ 32'hDEADBEEF;
            else mem_rdata <= tbmem[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model: booted flag, loader waiting count, pending error pulse, expected memory image.
    bit          m_run;
    int          m_waited;
    bit          m_err;
    bit          m_rv;
    bit          exp_ld;
    bit          exp_if;
    bit [31:0]   ref_mem [0:16383];
    logic [31:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_run    = 1'b0;
        m_waited = 0;
        m_err    = 1'b0;
        m_rv     = 1'b0;
        exp_ld   = 1'b0;
        exp_if   = 1'b0;
        sb.delete();
    endtask

    task automatic checkOutput(input logic [AW-1:0] la, input logic [DW-1:0] lw,
                               input bit ir, input logic [AW-1:0] ia);
        check("ld_gnt", 32'(ld_gnt), 32'(exp_ld));
        check("if_gnt", 32'(if_gnt), 32'(exp_if));
        check("cpu_stall", 32'(cpu_stall), 32'(!m_run || (ir && !exp_if)));
        check("boot_done", 32'(boot_done), 32'(m_run));
        check("ld_err", 32'(ld_err), 32'(m_err));
        check("if_rvalid", 32'(if_rvalid), 32'(m_rv));
        check("mem_en", 32'(mem_en), 32'(exp_ld || exp_if));
        check("mem_we", 32'(mem_we), 32'(exp_ld && int'(la) >= BASE));
        if (exp_ld) begin
            check("mem_addr_ld", 32'(mem_addr), 32'(la));
            check("mem_wdata", mem_wdata, lw);
        end else if (exp_if) begin
            check("mem_addr_if", 32'(mem_addr), 32'(ia));
        end
    endtask

    task automatic applyStimulus(input bit lr, input logic [AW-1:0] la, input logic [DW-1:0] lw,
                                 input bit ll, input bit ir, input logic [AW-1:0] ia);
        @(negedge clk);
        ld_req = lr; ld_addr = la; ld_wdata = lw; ld_last = ll;
        if_req = ir; if_addr = ia;
        #1;
        exp_ld = 1'b0;
        exp_if = 1'b0;
        if (!m_run) exp_ld = lr;
        else if (lr && m_waited >= SMAX) exp_ld = 1'b1;
        else if (ir) exp_if = 1'b1;
        else exp_ld = lr;
        checkOutput(la, lw, ir, ia);
        if (exp_ld && int'(la) >= BASE) ref_mem[la] = lw;
        if (exp_if) sb.push_back((int'(ia) < BASE) ? 32'h0 : ref_mem[ia]);
        m_err = exp_ld && int'(la) < BASE;
        m_rv  = exp_if;
        if (m_run) begin
            if (exp_ld || !lr) m_waited = 0;
            else if (m_waited < SMAX) m_waited = m_waited + 1;
        end
        if (!m_run && exp_ld && ll) m_run = 1'b1;
    endtask

    // Fetch scoreboard: every presented word must match the oldest outstanding expected word.
    always @(posedge clk) begin
        logic [31:0] d;
        #2;
        if (rst_n && if_rvalid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL if_rvalid_unexpected: got rvalid=1 expected no outstanding fetch at %0t", $time);
            end else begin
                d = sb.pop_front();
                check("if_rdata", if_rdata, d);
            end
        end
    end

    function automatic logic [AW-1:0] randAddr();
        if ($urandom_range(0, 7) == 0) return AW'($urandom_range(0, BASE - 1));
        return AW'(BASE + $urandom_range(0, 15));
    endfunction

    initial begin
        logic [31:0] prog [3];
        bit          pend;
        bit          got;
        int          gcycle;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        prog[0] = 32'h20080005;
        prog[1] = 32'h20090003;
        prog[2] = 32'h01095020;
        modelReset();

        #3;
        check("rst_cpu_stall", 32'(cpu_stall), 32'd1);
        check("rst_boot_done", 32'(boot_done), 32'd0);
        check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst_ld_err", 32'(ld_err), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Boot load of three words; fetch also requests on the first to see it held off.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, AW'(BASE + i), prog[i], i == 2, i == 0, AW'(BASE));

        // Streaming fetch of the loaded words.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, AW'(BASE + i));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);

        // Continuous fetch against a waiting loader: forced grant on the 5th requesting cycle.
        got = 1'b0;
        gcycle = -1;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(!got, AW'(BASE + 3), 32'hCAFEF00D, 1'b0, 1'b1, AW'(BASE + (i % 3)));
            if (ld_gnt && !got) begin
                got = 1'b1;
                gcycle = i;
            end
        end
        check("starve_grant_cycle", 32'(gcycle), 32'(SMAX + 1));

        // Out-of-range write, then a fetch from that region returns a nop.
        applyStimulus(1'b1, AW'(100), 32'h12345678, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, AW'(100));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, AW'(BASE + 3));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);

        pend = 1'b0;
        pa = AW'(BASE);
        pd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1'b1;
                pa = randAddr();
                pd = $urandom;
            end
            applyStimulus(pend, pa, pd, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, randAddr());
            if (exp_ld) pend = 1'b0;
        end

        // Reset asserted the cycle after a fetch grant.
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, AW'(BASE));
        @(posedge clk);
        #1;
        check("rvalid_before_reset", 32'(if_rvalid), 32'(sb.size() != 0));
        rst_n = 1'b0;
        #1;
        check("mid_rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("mid_rst_boot_done", 32'(boot_done), 32'd0);
        check("mid_rst_if_gnt", 32'(if_gnt), 32'd0);
        check("mid_rst_cpu_stall", 32'(cpu_stall), 32'd1);
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, AW'(BASE));
        applyStimulus(1'b1, AW'(BASE + 5), 32'h0BADF00D, 1'b1, 1'b1, AW'(BASE));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, AW'(BASE + 5));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
